// File: rtl/uart_tx.sv
// uart_tx: memory-mapped 8N1 serial transmitter with a byte FIFO, programmable bit period and drain interrupt.
module uart_tx #(
  parameter logic [15:0] BASEADDR   = 16'h0010,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dread_addr,
  output logic [15:0] dread_data,
  input  logic [15:0] dwrite_addr,
  input  logic [15:0] dwrite_data,
  input  logic [1:0]  dwrite_en,
  output logic        txd,
  output logic        interrupt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic          txd_q, txd_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bit_q, bit_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   div_q, div_d;
  logic          irq_en_q, irq_en_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   rd_q, rd_d;
  logic          int_q, int_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          wr_hit, rd_hit, push, pop, accept, full, empty, tick;
  logic [1:0]    wr_off, rd_off;
  logic [15:0]   div_eff, status;
  logic          unused;
  assign unused  = ^{dread_addr[0], dwrite_addr[0]};
  assign wr_hit  = |dwrite_en && dwrite_addr[15:3] == BASEADDR[15:3];
  assign rd_hit  = dread_addr[15:3] == BASEADDR[15:3];
  assign wr_off  = dwrite_addr[2:1];
  assign rd_off  = dread_addr[2:1];
  assign full    = count_q == CW'(FIFO_DEPTH);
  assign empty   = count_q == '0;
  assign tick    = cnt_q <= 16'd1;
  assign div_eff = div_q == 16'd0 ? 16'd1 : div_q;
  assign push    = wr_hit && wr_off == 2'd0 && dwrite_en[0];
  assign accept  = push && (!full || pop);
  assign status  = {11'd0, ovf_q, irq_en_q, empty, full, state_q != IDLE};
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      txd_q    <= 1'b1;
      sh_q     <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      div_q    <= DIV_RESET;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      rd_q     <= '0;
      int_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      txd_q    <= txd_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      rd_q     <= rd_d;
      int_q    <= int_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) if (accept) mem_q[wptr_q] <= dwrite_data[7:0];
  always_comb begin
    pop     = !empty && (state_q == IDLE || (state_q == STOP && tick));
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = empty ? IDLE : START;
      START: state_d = tick ? DATA : START;
      DATA:  state_d = (tick && bit_q == 3'd7) ? STOP : DATA;
      STOP:  state_d = !tick ? STOP : empty ? IDLE : START;
    endcase
  end
  // Shifter datapath: a pop always starts a frame, otherwise act only on bit boundaries.
  always_comb begin
    txd_d = txd_q;
    sh_d  = sh_q;
    bit_d = bit_q;
    cnt_d = tick ? cnt_q : cnt_q - 16'd1;
    if (pop) begin
      txd_d = 1'b0;
      sh_d  = mem_q[rptr_q];
      cnt_d = div_eff;
    end else if (tick && state_q != IDLE) begin
      cnt_d = div_eff;
      bit_d = state_q == START ? 3'd0 : bit_q + 3'd1;
      txd_d = (state_q == STOP || (state_q == DATA && bit_q == 3'd7)) ? 1'b1 : sh_q[0];
      sh_d  = sh_q >> 1;
    end
  end
  always_comb begin
    wptr_d   = wptr_q + AW'(accept);
    rptr_d   = rptr_q + AW'(pop);
    count_d  = count_q + CW'(accept) - CW'(pop);
    ovf_d    = (ovf_q & ~(wr_hit && wr_off == 2'd1 && dwrite_en[0] && dwrite_data[4])) | (push & full & ~pop);
    irq_en_d = (wr_hit && wr_off == 2'd1 && dwrite_en[0]) ? dwrite_data[3] : irq_en_q;
    div_d[7:0]  = (wr_hit && wr_off == 2'd2 && dwrite_en[0]) ? dwrite_data[7:0]  : div_q[7:0];
    div_d[15:8] = (wr_hit && wr_off == 2'd2 && dwrite_en[1]) ? dwrite_data[15:8] : div_q[15:8];
    rd_d     = !rd_hit ? 16'd0 : rd_off == 2'd1 ? status : rd_off == 2'd2 ? div_q : 16'd0;
    int_d    = irq_en_q & empty & (state_q == IDLE);
  end
  assign dread_data = rd_q;
  assign txd        = txd_q;
  assign interrupt  = int_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed register/line checks plus a txd frame decoder scoreboard for uart_tx.
module tb_uart_tx;
  localparam logic [15:0] B = 16'h0010;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dread_addr, dread_data, dwrite_addr, dwrite_data;
  logic [1:0]  dwrite_en;
  logic        txd, interrupt;
  int          checks = 0, errors = 0;
  logic [7:0]  exp_q [$];
  logic        mon_en = 1'b0;
  int          cur_div = 16;
  logic [7:0]  mon_b;
  logic [7:0]  pat;
  int          lows, his;
  uart_tx #(.BASEADDR(B), .FIFO_DEPTH(4), .DIV_RESET(16'd16)) dut (
    .clk(clk), .reset(reset), .dread_addr(dread_addr), .dread_data(dread_data),
    .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data), .dwrite_en(dwrite_en),
    .txd(txd), .interrupt(interrupt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] en);
    dwrite_addr = a;
    dwrite_data = d;
    dwrite_en   = en;
    @(posedge clk);
    #1 dwrite_en = 2'b00;
  endtask
  task automatic rdchk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    dread_addr = a;
    @(posedge clk);
    #1 chk(tag, dread_data, exp);
  endtask
  task automatic drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2 * cur_div + 4) @(posedge clk);
    #1 chk("drain", 16'(exp_q.size()), 16'd0);
  endtask
  // Decode frames from the line, sampling each bit near or after its centre.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        repeat (cur_div / 2) @(negedge clk);
        chk("start_bit", {15'd0, txd}, 16'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (cur_div) @(negedge clk);
          mon_b[i] = txd;
        end
        repeat (cur_div) @(negedge clk);
        chk("stop_bit", {15'd0, txd}, 16'd1);
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL frame_unexpected: observed %h expected none", mon_b);
        end
        if (exp_q.size() != 0) chk("frame_byte", {8'd0, mon_b}, {8'd0, exp_q.pop_front()});
      end
    end
  end
  initial begin
    reset = 1'b1; dwrite_en = 2'b00; dread_addr = 16'h0; dwrite_addr = 16'h0; dwrite_data = 16'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_txd", {15'd0, txd}, 16'd1);
    chk("rst_int", {15'd0, interrupt}, 16'd0);
    chk("rst_rdata", dread_data, 16'd0);
    // reset in the middle of a frame
    wr(B + 2, 16'h0008, 2'b01);
    wr(B, 16'h00AA, 2'b01);
    repeat (20) @(posedge clk);
    #1 chk("pre_reset_bit0", {15'd0, txd}, 16'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("reset_txd_next_edge", {15'd0, txd}, 16'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    rdchk("reset_status", B + 2, 16'h0004);
    rdchk("reset_div", B + 4, 16'd16);
    chk("reset_int", {15'd0, interrupt}, 16'd0);
    lows = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1 if (txd !== 1'b1) lows++;
    end
    chk("no_resume", 16'(lows), 16'd0);
    mon_en = 1'b1;
    // single frame, DIV=4
    cur_div = 4;
    wr(B + 4, 16'd4, 2'b11);
    dread_addr = B + 2;
    exp_q.push_back(8'h55);
    wr(B, 16'h0055, 2'b01);
    chk("sf_idle_after_push", {15'd0, txd}, 16'd1);
    pat = 8'h55;
    for (int k = 1; k <= 42; k++) begin
      @(posedge clk);
      #1 chk("sf_txd", {15'd0, txd}, {15'd0, k <= 4 ? 1'b0 : k <= 36 ? pat[(k - 5) / 4] : 1'b1});
      if (k == 40) chk("sf_busy_stop", {15'd0, dread_data[0]}, 16'd1);
      if (k == 42) chk("sf_busy_clear", {15'd0, dread_data[0]}, 16'd0);
    end
    // back-to-back frames, DIV=2
    cur_div = 2;
    wr(B + 4, 16'd2, 2'b11);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    wr(B, 16'h00A3, 2'b01);
    wr(B, 16'h000F, 2'b01);
    for (int k = 2; k <= 42; k++) begin
      @(posedge clk);
      #1;
      if (k == 20) chk("b2b_stop1", {15'd0, txd}, 16'd1);
      if (k == 21) chk("b2b_start2", {15'd0, txd}, 16'd0);
      if (k == 40) chk("b2b_stop2", {15'd0, txd}, 16'd1);
      if (k == 41) chk("b2b_busy_last", {15'd0, dread_data[0]}, 16'd1);
      if (k == 42) chk("b2b_busy_clear", {15'd0, dread_data[0]}, 16'd0);
    end
    drain(200);
    // interrupt, DIV=2
    wr(B + 2, 16'h0008, 2'b01);
    exp_q.push_back(8'h3C);
    wr(B, 16'h003C, 2'b01);
    his = 0;
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk);
      #1 if (interrupt !== 1'b0) his++;
    end
    chk("int_low_while_busy", 16'(his), 16'd0);
    @(posedge clk);
    #1 chk("int_rise", {15'd0, interrupt}, 16'd1);
    wr(B + 2, 16'h0000, 2'b01);
    @(posedge clk);
    #1 chk("int_clear", {15'd0, interrupt}, 16'd0);
    drain(100);
    // overflow: one byte in flight, four queued, sixth dropped
    cur_div = 20;
    wr(B + 4, 16'd20, 2'b11);
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) exp_q.push_back(8'(i * 8'h11));
      wr(B, 16'(i * 8'h11), 2'b01);
    end
    rdchk("ovf_status", B + 2, 16'h0013);
    wr(B + 2, 16'h0010, 2'b01);
    rdchk("ovf_cleared", B + 2, 16'h0003);
    drain(1500);
    // DIV=0 acts as DIV=1
    cur_div = 1;
    wr(B + 4, 16'd0, 2'b11);
    rdchk("div_zero_read", B + 4, 16'd0);
    exp_q.push_back(8'hC6);
    wr(B, 16'h00C6, 2'b01);
    drain(100);
    // byte lanes and address decode
    mon_en = 1'b0;
    wr(B + 4, 16'h0010, 2'b11);
    wr(B + 4, 16'hABCD, 2'b10);
    rdchk("div_high_lane", B + 4, 16'hAB10);
    wr(B + 8, 16'h1234, 2'b11);
    wr(B + 6, 16'hFFFF, 2'b11);
    rdchk("div_after_outside", B + 4, 16'hAB10);
    rdchk("status_after_outside", B + 2, 16'h0004);
    rdchk("reserved_read", B + 6, 16'h0000);
    rdchk("div_reread", B + 4, 16'hAB10);
    rdchk("outside_read", B + 8, 16'h0000);
    rdchk("data_read", B, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
